bin_to_bcd_seq: RTL and testbench
=================================

Name: bin_to_bcd_seq

Overview:
- Sequential (shift-add-3, "double dabble") binary-to-BCD converter.
- Sits between the memory-mapped display data register and the seven-segment display interface.
- Takes a 32-bit unsigned word on a start pulse and produces DIGITS packed BCD digits after a fixed latency.
- Holds the result stable for the display multiplexer until the next conversion completes; saturates to all-nines when the value does not fit.

Parameters:
- IN_WIDTH, 32, width of the unsigned binary input.
- DIGITS, 4, number of BCD output digits; maximum representable value MAXV = 10^DIGITS - 1 (9999 at default).

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-high reset.
- start, input, 1, request a conversion of bin; sampled only in IDLE.
- bin, input, IN_WIDTH, unsigned binary value; captured on the cycle start is accepted.
- busy, output, 1, high from the cycle after acceptance through the DONE cycle.
- done, output, 1, one-cycle pulse when bcd/overflow update.
- bcd, output, 4*DIGITS, packed BCD, most significant digit in the top nibble (thousands,hundreds,tens,ones at default).
- overflow, output, 1, set when the last converted value exceeded MAXV.

Behaviour:
- Reset (async, any time, including mid-conversion):
  - state=IDLE; busy=0, done=0, bcd=0, overflow=0.
  - Shift and scratch registers cleared; any in-flight conversion is discarded.
- State machine: IDLE -> CONVERT -> DONE -> IDLE.
- IDLE:
  - If start=1: capture bin into the shift register.
  - Compute ovf_pending = (bin > MAXV) as an unsigned comparison at full IN_WIDTH.
  - Clear the BCD scratch register to 0 and the iteration counter to 0; go to CONVERT.
- CONVERT, one iteration per cycle, exactly IN_WIDTH cycles:
  - For each scratch digit >= 5, add 3 (4-bit add, no carry across digits).
  - Then shift {scratch, shift_reg} left by one bit.
  - Scratch is DIGITS*4 bits wide; bits shifted out of the top are discarded. This only happens in the overflow case, where the result is replaced anyway.
  - The counter reaches IN_WIDTH-1 on the last iteration, then the state goes to DONE.
- DONE, one cycle:
  - bcd <= ovf_pending ? all digits 4'h9 : scratch.
  - overflow <= ovf_pending; done=1; next state IDLE.
- Latency:
  - start accepted at edge N -> done high and bcd valid during the cycle after edge N+IN_WIDTH+1 (33 cycles at default).
  - Latency is fixed and independent of the value or overflow.
- busy:
  - busy=1 in CONVERT and DONE; busy=0 in IDLE.
  - start while busy=1 is ignored, not queued.
  - start asserted in the DONE cycle is ignored; the earliest next acceptance is the following cycle (IDLE).
- Output stability:
  - bcd and overflow change only in the DONE cycle (or on reset).
  - Intermediate scratch values never appear on bcd.
- bin:
  - Sampled only at acceptance; changes to bin during a conversion have no effect.
  - No signed interpretation.
- start held high continuously: a new conversion is accepted every IN_WIDTH+2 cycles.
- Every emitted digit is in 0..9; an invalid nibble (A–F) on bcd is a design error.

Test Plan:
- Reset, then start with bin=0 -> done after 33 cycles, bcd=16'h0000, overflow=0; busy high for exactly 33 cycles.
- bin=1234 -> bcd=16'h1234, overflow=0. Then bin=9999 -> bcd=16'h9999, overflow=0. Then bin=7 -> bcd=16'h0007 (bcd holds 16'h9999 until that done).
- bin=10000 -> bcd=16'h9999, overflow=1. bin=32'hFFFFFFFF -> bcd=16'h9999, overflow=1. A following bin=42 -> bcd=16'h0042, overflow=0.
- start at bin=55, then start pulses with bin=88 at cycles +5 and in the DONE cycle -> exactly one done, bcd=16'h0055; start one cycle after done with bin=88 -> bcd=16'h0088.
- Reset asserted asynchronously mid-CONVERT (cycle +10 of a bin=4321 run) -> busy, done, bcd and overflow go to 0 immediately with no done pulse. After release, start bin=4321 -> bcd=16'h4321 at the normal latency.
- Random sweep of 0..9999 plus random 32-bit values against a reference model -> every done has bcd equal to the decimal digits or saturated 9999, overflow correct, latency always 33.

Source files
------------

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq
// Sequential shift-add-3 ("double dabble") binary-to-BCD converter that sits
// between the display data register and the seven-segment driver. A start
// pulse captures an unsigned word; after a fixed latency the packed BCD result
// (or all nines if the value does not fit in DIGITS digits) is published on
// bcd together with a one-cycle done pulse. bcd/overflow hold their value
// between conversions so the display multiplexer always sees a stable number.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start     conversion request, sampled only while idle
//   bin       unsigned binary input, captured when start is accepted
//   busy      high while a conversion is in flight (CONVERT and DONE states)
//   done      one-cycle pulse when bcd/overflow are updated
//   bcd       packed BCD result, most significant digit in the top nibble
//   overflow  last converted value exceeded 10^DIGITS - 1
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start; result registers hold last conversion
// CONVERT | one add-3/shift iteration per cycle, IN_WIDTH cycles
// DONE    | publish result (or saturate), pulse done, return to IDLE

module bin_to_bcd_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam logic [IN_WIDTH-1:0] MAXV     = IN_WIDTH'(10 ** DIGITS - 1);
  localparam logic [CW-1:0]       LAST_CNT = CW'(IN_WIDTH - 1);
  localparam logic [BW-1:0]       ALL_NINE = {DIGITS{4'h9}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shift_reg;
  logic [BW-1:0]       scratch;
  logic [CW-1:0]       cnt;
  logic                ovf_pending;

  logic [BW-1:0]       adj;
  logic [BW-1:0]       scratch_next;
  logic [IN_WIDTH-1:0] shift_next;

  // Per-digit add-3 correction, then one left shift of {scratch, shift_reg}.
  // The scratch MSB falls off the top; that only happens for values that
  // overflow, whose result is replaced by all nines anyway.
  always_comb begin
    adj = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
    scratch_next = {adj[BW-2:0], shift_reg[IN_WIDTH-1]};
    shift_next   = {shift_reg[IN_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      shift_reg   <= '0;
      scratch     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      bcd         <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg   <= bin;
            ovf_pending <= (bin > MAXV);
            scratch     <= '0;
            cnt         <= '0;
            busy        <= 1'b1;
            state       <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          scratch   <= scratch_next;
          shift_reg <= shift_next;
          cnt       <= cnt + 1'b1;
          if (cnt == LAST_CNT)
            state <= ST_DONE;
        end
        ST_DONE: begin
          bcd      <= ovf_pending ? ALL_NINE : scratch;
          overflow <= ovf_pending;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        overflow;

  bin_to_bcd_seq #(.IN_WIDTH(32), .DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  exp_t prev_exp;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [31:0] v);
    exp_t r;
    if (v > 32'd9999) begin
      r.bcd = 16'h9999;
      r.ovf = 1'b1;
    end else begin
      r.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      r.ovf = 1'b0;
    end
    return r;
  endfunction

  function automatic bit valid_bcd(input logic [15:0] x);
    bit ok = 1'b1;
    for (int d = 0; d < 4; d++)
      if (x[4*d +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  // Drives one conversion and reports what the DUT did; expectation is pushed
  // to the scoreboard at the moment the stimulus is driven.
  task automatic convert(input logic [31:0] v, output logic [15:0] got_bcd,
                         output logic got_ovf, output int lat,
                         output int busy_cnt, output bit stable);
    @(posedge clk); #1;
    start = 1'b1;
    bin   = v;
    sb.push_back(model(v));
    @(posedge clk); #1;
    start    = 1'b0;
    bin      = $urandom;
    busy_cnt = busy ? 1 : 0;
    stable   = 1'b1;
    lat      = -1;
    got_bcd  = 16'hxxxx;
    got_ovf  = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin
        lat     = i;
        got_bcd = bcd;
        got_ovf = overflow;
        break;
      end
      if (busy) busy_cnt++;
      if (bcd !== prev_exp.bcd || overflow !== prev_exp.ovf) stable = 1'b0;
    end
    prev_exp = model(v);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    prev_exp = '0;
    #12;
    n_checks++;
    if ({busy, done, overflow, bcd} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_state got busy=%b done=%b ovf=%b bcd=%h expected all zero",
               busy, done, overflow, bcd);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] vals [4] = '{32'd0, 32'd1234, 32'd9999, 32'd7};
    logic [15:0] gb;
    logic        go;
    int          lat, bc;
    bit          st;
    exp_t        e;
    for (int k = 0; k < 4; k++) begin
      convert(vals[k], gb, go, lat, bc, st);
      e = sb.pop_front();
      n_checks += 6;
      if (gb !== e.bcd) begin
        n_fail++; $display("FAIL basic_bcd v=%0d got=%h expected=%h", vals[k], gb, e.bcd);
      end
      if (go !== e.ovf) begin
        n_fail++; $display("FAIL basic_ovf v=%0d got=%b expected=%b", vals[k], go, e.ovf);
      end
      if (lat != 33) begin
        n_fail++; $display("FAIL basic_latency v=%0d got=%0d expected=33", vals[k], lat);
      end
      if (bc != 33) begin
        n_fail++; $display("FAIL basic_busy_cycles v=%0d got=%0d expected=33", vals[k], bc);
      end
      if (!st) begin
        n_fail++; $display("FAIL basic_hold v=%0d bcd/overflow changed before done (expected hold %h)",
                           vals[k], e.bcd);
      end
      if (!valid_bcd(gb)) begin
        n_fail++; $display("FAIL basic_nibbles v=%0d got=%h expected digits 0..9", vals[k], gb);
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] vals [3] = '{32'd10000, 32'hFFFF_FFFF, 32'd42};
    logic [15:0] gb;
    logic        go;
    int          lat, bc;
    bit          st;
    exp_t        e;
    for (int k = 0; k < 3; k++) begin
      convert(vals[k], gb, go, lat, bc, st);
      e = sb.pop_front();
      n_checks += 4;
      if (gb !== e.bcd) begin
        n_fail++; $display("FAIL ovf_bcd v=%0h got=%h expected=%h", vals[k], gb, e.bcd);
      end
      if (go !== e.ovf) begin
        n_fail++; $display("FAIL ovf_flag v=%0h got=%b expected=%b", vals[k], go, e.ovf);
      end
      if (lat != 33) begin
        n_fail++; $display("FAIL ovf_latency v=%0h got=%0d expected=33", vals[k], lat);
      end
      if (!st) begin
        n_fail++; $display("FAIL ovf_hold v=%0h output changed before done", vals[k]);
      end
    end
  endtask

  // start at +5 and in the DONE-state cycle is ignored; start one cycle after
  // done (bin=88) is accepted, giving a second done 34 cycles after the first.
  task automatic test_ignore_start();
    int   n_done = 0;
    int   t_done [2] = '{-1, -1};
    logic [15:0] b_done [2];
    logic busy_after;
    exp_t e;
    busy_after = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; bin = 32'd55;
    sb.push_back(model(32'd55));
    @(posedge clk); #1;
    start = 1'b0; bin = 32'd88;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (n_done < 2) begin
          t_done[n_done] = i;
          b_done[n_done] = bcd;
        end
        n_done++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL ignore_extra_done at cycle %0d bcd=%h expected no done", i, bcd);
        end else begin
          e = sb.pop_front();
          if (bcd !== e.bcd || overflow !== e.ovf) begin
            n_fail++; $display("FAIL ignore_result got=%h/%b expected=%h/%b", bcd, overflow, e.bcd, e.ovf);
          end
        end
      end
      if (i == 4)  start = 1'b1;
      if (i == 5)  start = 1'b0;
      if (i == 32) start = 1'b1;
      if (i == 33) sb.push_back(model(32'd88));
      if (i == 34) begin
        busy_after = busy;
        start = 1'b0;
      end
    end
    prev_exp = model(32'd88);
    n_checks += 4;
    if (n_done != 2) begin
      n_fail++; $display("FAIL ignore_done_count got=%0d expected=2", n_done);
    end
    if (t_done[0] != 33 || b_done[0] !== 16'h0055) begin
      n_fail++; $display("FAIL ignore_first got cycle=%0d bcd=%h expected cycle=33 bcd=0055",
                         t_done[0], b_done[0]);
    end
    if (t_done[1] != 67 || b_done[1] !== 16'h0088) begin
      n_fail++; $display("FAIL ignore_second got cycle=%0d bcd=%h expected cycle=67 bcd=0088",
                         t_done[1], b_done[1]);
    end
    if (busy_after !== 1'b1) begin
      n_fail++; $display("FAIL ignore_accept_after_done busy=%b expected=1", busy_after);
    end
  endtask

  task automatic test_back_to_back();
    int   t_done [$];
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; bin = 32'd111;
    sb.push_back(model(32'd111));
    for (int i = 0; i <= 80; i++) begin
      @(posedge clk); #1;
      if (done) begin
        t_done.push_back(i);
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_done at cycle %0d", i);
        end else begin
          e = sb.pop_front();
          if (bcd !== e.bcd || overflow !== e.ovf) begin
            n_fail++; $display("FAIL b2b_result got=%h/%b expected=%h/%b", bcd, overflow, e.bcd, e.ovf);
          end
        end
      end
      if (i == 0) begin
        bin = 32'd222;
        sb.push_back(model(32'd222));
      end
      if (i == 34) start = 1'b0;
    end
    prev_exp = model(32'd222);
    n_checks++;
    if (t_done.size() != 2 || t_done[0] != 33 || t_done[1] != 67) begin
      n_fail++; $display("FAIL b2b_spacing got %0d dones first=%0d expected dones at 33 and 67",
                         t_done.size(), (t_done.size() > 0) ? t_done[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int          n_done = 0;
    logic [15:0] gb;
    logic        go;
    int          lat, bc;
    bit          st;
    exp_t        e;
    @(posedge clk); #1;
    start = 1'b1; bin = 32'd4321;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, overflow, bcd} !== 19'd0) begin
      n_fail++;
      $display("FAIL midreset_clear got busy=%b done=%b ovf=%b bcd=%h expected all zero",
               busy, done, overflow, bcd);
    end
    prev_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    n_checks++;
    if (n_done != 0) begin
      n_fail++; $display("FAIL midreset_no_done got=%0d dones expected=0", n_done);
    end
    convert(32'd4321, gb, go, lat, bc, st);
    e = sb.pop_front();
    n_checks += 2;
    if (gb !== e.bcd || go !== e.ovf) begin
      n_fail++; $display("FAIL midreset_rerun got=%h/%b expected=%h/%b", gb, go, e.bcd, e.ovf);
    end
    if (lat != 33) begin
      n_fail++; $display("FAIL midreset_latency got=%0d expected=33", lat);
    end
  endtask

  task automatic test_random();
    logic [31:0] v;
    logic [15:0] gb;
    logic        go;
    int          lat, bc;
    bit          st;
    exp_t        e;
    for (int k = 0; k < 30; k++) begin
      v = (k < 20) ? 32'($urandom_range(0, 9999)) : $urandom;
      convert(v, gb, go, lat, bc, st);
      e = sb.pop_front();
      n_checks += 4;
      if (gb !== e.bcd || go !== e.ovf) begin
        n_fail++; $display("FAIL rand_result v=%0d got=%h/%b expected=%h/%b", v, gb, go, e.bcd, e.ovf);
      end
      if (lat != 33) begin
        n_fail++; $display("FAIL rand_latency v=%0d got=%0d expected=33", v, lat);
      end
      if (!st) begin
        n_fail++; $display("FAIL rand_hold v=%0d output changed before done", v);
      end
      if (!valid_bcd(gb)) begin
        n_fail++; $display("FAIL rand_nibbles v=%0d got=%h expected digits 0..9", v, gb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
